// File: rtl/wb_master_seq.sv
// wb_master_seq: in-order command FIFO feeding a Wishbone classic master.
// Optional bus timeout is enabled by defining WB_MASTER_SEQ_TIMEOUT_EN.
module wb_master_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 1 + 4 + 32 + 32;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;

    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_head_we;
    logic [3:0]    w_head_sel;
    logic [31:0]   w_head_adr;
    logic [31:0]   w_head_dat;
    logic          w_tmo_hit;

    logic          r_cyc;
    logic          r_we;
    logic [31:0]   r_adr;
    logic [31:0]   r_dat;
    logic [3:0]    r_sel;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_dat;
    logic          r_rsp_err;

    logic          w_cyc_nxt;
    logic          w_we_nxt;
    logic [31:0]   w_adr_nxt;
    logic [31:0]   w_dat_nxt;
    logic [3:0]    w_sel_nxt;
    logic          w_rsp_valid_nxt;
    logic [31:0]   w_rsp_dat_nxt;
    logic          w_rsp_err_nxt;

    // A full FIFO refuses a push even when a pop happens on the same edge.
    assign w_ready = (r_cnt != FULL);
    assign w_push  = cmd_valid_i && w_ready;
    assign {w_head_we, w_head_sel, w_head_adr, w_head_dat} = r_mem[r_rd_ptr];

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i};
        end
    end

    // FIFO pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef WB_MASTER_SEQ_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;

    // Counts bus cycles of the current transfer; idle time keeps it at zero.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_tmo_cnt <= '0;
        end else if (r_state != S_BUS) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo_hit = (r_state == S_BUS) && (r_tmo_cnt == TMO_LIM);
`else
    logic w_unused_tmo;

    assign w_unused_tmo = ^TMO_LIM;
    assign w_tmo_hit    = 1'b0;
`endif

    // State and registered bus/response outputs.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_state     <= S_IDLE;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cyc       <= w_cyc_nxt;
            r_we        <= w_we_nxt;
            r_adr       <= w_adr_nxt;
            r_dat       <= w_dat_nxt;
            r_sel       <= w_sel_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_dat   <= w_rsp_dat_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    // Next state: issue head, wait for ack/err/timeout, hold the response.
    always_comb begin
        w_state_nxt     = r_state;
        w_pop           = 1'b0;
        w_cyc_nxt       = r_cyc;
        w_we_nxt        = r_we;
        w_adr_nxt       = r_adr;
        w_dat_nxt       = r_dat;
        w_sel_nxt       = r_sel;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_dat_nxt   = r_rsp_dat;
        w_rsp_err_nxt   = r_rsp_err;
        unique case (r_state)
            S_IDLE: begin
                if (r_cnt != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_BUS;
                    w_cyc_nxt   = 1'b1;
                    w_we_nxt    = w_head_we;
                    w_adr_nxt   = w_head_adr;
                    w_dat_nxt   = w_head_dat;
                    w_sel_nxt   = w_head_sel;
                end
            end
            S_BUS: begin
                // err beats ack; a real response beats the timeout.
                if (wbm_err_i || (!wbm_ack_i && w_tmo_hit)) begin
                    w_state_nxt     = S_RESP;
                    w_cyc_nxt       = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_dat_nxt   = '0;
                    w_rsp_err_nxt   = 1'b1;
                end else if (wbm_ack_i) begin
                    w_state_nxt     = S_RESP;
                    w_cyc_nxt       = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_dat_nxt   = r_we ? 32'h0 : wbm_dat_i;
                    w_rsp_err_nxt   = 1'b0;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cyc_nxt   = 1'b0;
            end
        endcase
    end

    assign cmd_ready_o = w_ready;
    assign busy_o      = (r_cnt != '0) || (r_state != S_IDLE);
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign wbm_sel_o   = r_sel;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;

endmodule

// File: doc/wb_master_seq.md
WB_MASTER_SEQ -- requirements
Module: wb_master_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 255, bus cycles allowed before a transfer is aborted (1..255).
REQ-003 SHALL have one clock and one reset: reset is synchronous and active-low.
REQ-004 wb_clk_i  in  1  sole clock, all logic on rising edge.
REQ-005 wb_rst_n_i  in  1  synchronous active-low reset.
REQ-006 cmd_valid_i  in  1  command offered.
REQ-007 cmd_ready_o  out  1  command FIFO not full.
REQ-008 cmd_we_i  in  1  1=write, 0=read.
REQ-009 cmd_adr_i  in  32  target byte address.
REQ-010 cmd_dat_i  in  32  write data.
REQ-011 cmd_sel_i  in  4  byte lane select.
REQ-012 rsp_valid_o  out  1  response held.
REQ-013 rsp_ready_i  in  1  response consumed.
REQ-014 rsp_dat_o  out  32  read data (0 for writes/errors).
REQ-015 rsp_err_o  out  1  wbm_err_i seen or timeout.
REQ-016 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic master controls.
REQ-017 wbm_adr_o  out  32; wbm_dat_o  out  32; wbm_sel_o  out  4  Wishbone master address/data/select.
REQ-018 wbm_dat_i  in  32; wbm_ack_i  in  1; wbm_err_i  in  1  Wishbone slave response.
REQ-019 busy_o  out  1  high when FIFO non-empty or state not IDLE.

Function
REQ-020 Command accepted on rising edge with cmd_valid_i & cmd_ready_o; fields pushed into FIFO, in-order.
REQ-021 cmd_ready_o SHALL be low exactly when FIFO holds FIFO_DEPTH entries; push and pop in same cycle when full SHALL be ignored for push (ready low).
REQ-022 FSM states IDLE, BUS, RESP.
REQ-023 IDLE -> BUS when FIFO non-empty: pop head, register adr/dat/sel/we onto wbm_* and assert wbm_cyc_o=wbm_stb_o=1 from the next edge; command accepted into empty idle block SHALL see cyc/stb high 2 edges after the accepting edge.
REQ-024 In BUS, wbm_* outputs SHALL stay stable until ack/err/timeout is sampled.
REQ-025 BUS, wbm_ack_i=1 sampled: drop cyc/stb same edge, rsp_dat_o=wbm_dat_i for reads else 0, rsp_err_o=0, -> RESP.
REQ-026 BUS, wbm_err_i=1 sampled: drop cyc/stb, rsp_dat_o=0, rsp_err_o=1, -> RESP; err SHALL take precedence over simultaneous ack.
REQ-027 RESP: rsp_valid_o=1; on edge with rsp_ready_i=1 -> IDLE and rsp_valid_o=0; next command SHALL NOT start until response consumed.
REQ-028 Timeout counter (8 bit) cleared on entry to BUS, increments each BUS cycle; when count==TIMEOUT and neither ack nor err sampled: abort as REQ-026 (err=1, dat=0); ack/err on that same edge SHALL win over timeout.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-030 All wbm_* and rsp_* outputs SHALL be registered.

Reset
REQ-031 On edge with wb_rst_n_i=0: FSM=IDLE, FIFO empty, counter 0, cyc/stb/we=0, adr/dat/sel=0, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, busy_o=0; cmd_ready_o=1 after reset released.
REQ-032 Reset asserted mid-transfer SHALL drop cyc/stb on that edge and discard queued commands and pending response.

Configuration
REQ-033 Macro WB_MASTER_SEQ_TIMEOUT_EN: defined -> REQ-028 timeout active; undefined -> no counter, BUS waits indefinitely for ack/err, TIMEOUT ignored.

Verification
REQ-034 Write adr 0x3000_1004 dat 0x0000_00FF sel 0xF, slave acks after 1 wait state -> cyc/stb 2 cycles, rsp_valid=1, rsp_err=0, rsp_dat=0.
REQ-035 Read adr 0x3000_2000, slave returns 0xA5A5_1234 with ack -> rsp_dat=0xA5A5_1234, rsp_err=0.
REQ-036 Push 5 commands with rsp_ready_i=0, FIFO_DEPTH=4 -> first popped, 4 queued, cmd_ready_o=0 until first response consumed; all 5 issued in order.
REQ-037 Slave never responds, TIMEOUT=8, macro defined -> cyc drops after 9 BUS cycles, rsp_err=1, rsp_dat=0; macro undefined -> cyc held 1000 cycles.
REQ-038 ack and err same cycle -> rsp_err=1; reset pulsed while cyc=1 with 2 queued -> cyc=0 next edge, busy_o=0, no response emitted.
